// File: rtl/kmeans_pkg.sv
// Shared constants and types for the K-means accumulator datapath blocks.
// Holds the operand width, the response-slot state type and the op counter width.
package kmeans_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : kmeans_pkg

// File: rtl/adder_share_arbiter_if.sv
// Requester/response bundle of adder_share_arbiter; rsp_ovf exists only with ADDER_ARB_OVF_EN.
// The slave modport is the arbiter side, the master modport is the requester/consumer side.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import kmeans_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic                      rsp_ovf;
`endif
    logic [CNT_W-1:0]          op_count;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
`ifdef ADDER_ARB_OVF_EN
        output rsp_ovf,
`endif
        output req_ready, rsp_valid, rsp_id, rsp_sum, op_count
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
`ifdef ADDER_ARB_OVF_EN
        input  rsp_ovf,
`endif
        input  req_ready, rsp_valid, rsp_id, rsp_sum, op_count
    );

endinterface : adder_share_arbiter_if

// File: rtl/adder_64_bit.sv
// Purpose: shared unsigned 64-bit adder, sum wraps modulo 2^64.
// Latency: purely combinational (0 cycles).
// Backpressure: none, the caller registers the result.
module adder_64_bit
    import kmeans_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule : adder_64_bit

// File: rtl/adder_share_arbiter.sv
// Purpose: round-robin share of one adder_64_bit among NUM_REQ requesters; ADDER_ARB_OVF_EN adds rsp_ovf.
// Latency: grant in cycle t, registered sum/id valid in cycle t+1.
// Backpressure: no grant while the response slot is held (FULL and rsp_ready low).
module adder_share_arbiter
    import kmeans_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic               slot_free;
    logic               rsp_hs;
    logic [DATA_W-1:0]  op_a, op_b, sum;
    logic [DATA_W-1:0]  sum_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // rst_n gates the slot so no requester sees a grant while reset is asserted.
    assign slot_free = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
    assign rsp_hs    = (state_q == FULL) && bus.rsp_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && slot_free && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

    assign op_a = bus.req_a[grant_idx*DATA_W +: DATA_W];
    assign op_b = bus.req_b[grant_idx*DATA_W +: DATA_W];

    adder_64_bit u_adder (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (sum)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;
        if (grant_vld) begin
            state_d  = FULL;
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (rsp_hs) begin
            state_d = EMPTY;
        end
        if (rsp_hs && (op_count_q != '1)) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            sum_q      <= '0;
            id_q       <= '0;
            op_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
            if (grant_vld) begin
                sum_q <= sum;
                id_q  <= grant_idx;
            end
        end
    end

`ifdef ADDER_ARB_OVF_EN
    logic ovf_d, ovf_q;

    assign ovf_d = (op_a[DATA_W-1] & op_b[DATA_W-1]) |
                   ((op_a[DATA_W-1] ^ op_b[DATA_W-1]) & ~sum[DATA_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (grant_vld) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.rsp_ovf = ovf_q;
`endif

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.op_count  = op_count_q;

endmodule : adder_share_arbiter

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with NUM_REQ=4; rsp_ovf checks compile in with ADDER_ARB_OVF_EN.
module tb_adder_share_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_share_arbiter_if #(.NUM_REQ(4)) bus ();

    adder_share_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        bus.req_a[i*64 +: 64] = a;
        bus.req_b[i*64 +: 64] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #3;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.rsp_sum !== 64'd0) begin errors++; $display("FAIL reset_rsp_sum: got %0h expected 0", bus.rsp_sum); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
        checks++; if (bus.op_count !== 32'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", bus.op_count); end
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        set_ops(1, 64'd5, 64'd7);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp_id: got %0d expected 1", bus.rsp_id); end
        checks++; if (bus.rsp_sum !== 64'd12) begin errors++; $display("FAIL single_rsp_sum: got %0d expected 12", bus.rsp_sum); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [63:0] exp_sum [4];
        logic [3:0]  exp_oh;
        logic [1:0]  exp_id;
        exp_sum[0] = 64'd103; exp_sum[1] = 64'd204; exp_sum[2] = 64'd305; exp_sum[3] = 64'd406;
        apply_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 64'(100 * (i + 1)), 64'(i + 3));
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_id = 2'(k % 4);
            exp_oh = 4'b0001 << exp_id;
            #1;
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, exp_oh); end
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== exp_id) begin errors++; $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", k, bus.rsp_id, exp_id); end
            checks++; if (bus.rsp_sum !== exp_sum[exp_id]) begin errors++; $display("FAIL rr_rsp_sum[%0d]: got %0d expected %0d", k, bus.rsp_sum, exp_sum[exp_id]); end
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        checks++; if (bus.op_count !== 32'd8) begin errors++; $display("FAIL rr_op_count: got %0d expected 8", bus.op_count); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b expected 0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.req_valid = 4'b0101;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: got %b expected 0001", bus.req_ready); end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_grant[%0d]: got %b expected 0000", j, bus.req_ready); end
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 64'd103) begin
                errors++; $display("FAIL bp_hold[%0d]: got valid=%b id=%0d sum=%0d expected valid=1 id=0 sum=103", j, bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_grant: got %b expected 0100", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_id !== 2'd2 || bus.rsp_sum !== 64'd305) begin
            errors++; $display("FAIL bp_resume_rsp: got id=%0d sum=%0d expected id=2 sum=305", bus.rsp_id, bus.rsp_sum);
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_wrap_overflow();
        @(negedge clk);
        set_ops(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant: got %b expected 1000", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_sum !== 64'd1 || bus.rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_sum: got sum=%0h id=%0d expected sum=1 id=3", bus.rsp_sum, bus.rsp_id); end
`ifdef ADDER_ARB_OVF_EN
        checks++; if (bus.rsp_ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b expected 1", bus.rsp_ovf); end
`endif
        @(negedge clk);
        set_ops(3, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        checks++; if (bus.rsp_sum !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL nowrap_sum: got %0h expected ffffffffffffffff", bus.rsp_sum); end
`ifdef ADDER_ARB_OVF_EN
        checks++; if (bus.rsp_ovf !== 1'b0) begin errors++; $display("FAIL nowrap_ovf: got %b expected 0", bus.rsp_ovf); end
`endif
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_ops(0, 64'd100, 64'd3);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.rsp_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 64'd0 || bus.rsp_id !== 2'd0) begin
            errors++; $display("FAIL mid_rsp_cleared: got valid=%b sum=%0d id=%0d expected all 0", bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
        end
        checks++; if (bus.op_count !== 32'd0) begin errors++; $display("FAIL mid_op_count: got %0d expected 0", bus.op_count); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_req_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== 64'd103) begin errors++; $display("FAIL mid_first_rsp: got id=%0d sum=%0d expected id=0 sum=103", bus.rsp_id, bus.rsp_sum); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.op_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.op_count_q;
        checks++; if (bus.op_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preset: got %0h expected fffffffe", bus.op_count); end
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        checks++; if (bus.op_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_step: got %0h expected ffffffff", bus.op_count); end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(posedge clk); #1;
        checks++; if (bus.op_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffffffff", bus.op_count); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL sat_drained: got %b expected 0", bus.rsp_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.req_valid = 4'b0000;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap_overflow();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_share_arbiter
